l2_mem_responder: RTL and testbench



---
 rtl/l2_mem_responder.sv | 103 ++++++++++
 tb/tb_l2_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// Fixed-latency L2 model for the L1 miss path: single-word writes, single or 8-word line reads.
// Optional build macro L2_RSP_CRIT_WORD_FIRST_EN makes bursts start at the requested word and wrap.
module l2_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_burst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        wr_ack,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_idx,
    output logic        rsp_last
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT} state_t;

    state_t            state, state_n;
    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] base_q;
    logic              burst_q;
    logic [3:0]        lat_q;
    logic [3:0]        beat_cnt_q;
    logic [2:0]        off_q;
    logic [2:0]        start_off;
    logic              wr_acc, rd_acc, beat_last;
    logic              unused_addr;

    assign unused_addr = &{1'b0, req_addr[31:ADDR_W]};

    assign req_ready = (state == IDLE);
    assign wr_acc    = req_valid & req_ready & req_wr;
    assign rd_acc    = req_valid & req_ready & ~req_wr;
    assign beat_last = burst_q ? (beat_cnt_q == 4'd7) : 1'b1;

`ifdef L2_RSP_CRIT_WORD_FIRST_EN
    assign start_off = req_addr[2:0];
`else
    assign start_off = req_burst ? 3'd0 : req_addr[2:0];
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rd_acc) state_n = (RD_LAT == 1) ? RD_BEAT : RD_WAIT;
            RD_WAIT: if (lat_q == 4'd1) state_n = RD_BEAT;
            RD_BEAT: if (beat_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Array is deliberately not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[req_addr[ADDR_W-1:0]] <= req_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_idx    <= 3'd0;
            rsp_last   <= 1'b0;
            base_q     <= '0;
            burst_q    <= 1'b0;
            lat_q      <= 4'd0;
            beat_cnt_q <= 4'd0;
            off_q      <= 3'd0;
        end else begin
            wr_ack    <= wr_acc;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rd_acc) begin
                base_q     <= req_addr[ADDR_W-1:0];
                burst_q    <= req_burst;
                lat_q      <= 4'(RD_LAT - 1);
                off_q      <= start_off;
                beat_cnt_q <= 4'd0;
            end
            if (state == RD_WAIT) lat_q <= lat_q - 4'd1;
            if (state == RD_BEAT) begin
                rsp_valid  <= 1'b1;
                rsp_data   <= mem[{base_q[ADDR_W-1:3], off_q}];
                rsp_idx    <= off_q;
                rsp_last   <= beat_last;
                off_q      <= off_q + 3'd1;
                beat_cnt_q <= beat_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder (ADDR_W=10, RD_LAT=2); inputs driven and outputs sampled on negedge.
module tb_l2_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_burst = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        wr_ack;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_idx;
    logic        rsp_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l2_mem_responder #(.ADDR_W(10), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
        .wr_ack(wr_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_idx(rsp_idx), .rsp_last(rsp_last)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic wr, input logic bu,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v; req_wr = wr; req_burst = bu; req_addr = a; req_wdata = d;
    endtask

    task automatic preload_line();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h10 + i, 32'h100 + i);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_cmp++; if (rsp_idx !== 3'd0) begin n_err++; $display("FAIL reset_rsp_idx got %0d want 0", rsp_idx); end
        n_cmp++; if (rsp_last !== 1'b0) begin n_err++; $display("FAIL reset_rsp_last got %b want 0", rsp_last); end
    endtask

    task automatic test_write_single_read();
        drive(1'b1, 1'b1, 1'b0, 32'h13, 32'hDEADBEEF);
        tick();
        n_cmp++; if (wr_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack_pulse got %b want 1", wr_ack); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_write got %b want 1", req_ready); end
        drive(1'b1, 1'b0, 1'b0, 32'h13, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_clear got %b want 0", wr_ack); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_beat got %b want 0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h want deadbeef", rsp_data); end
        n_cmp++; if (rsp_idx !== 3'd3) begin n_err++; $display("FAIL single_idx got %0d want 3", rsp_idx); end
        n_cmp++; if (rsp_last !== 1'b1) begin n_err++; $display("FAIL single_last got %b want 1", rsp_last); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_on_last got %b want 1", req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_one_beat got %b want 0", rsp_valid); end
    endtask

    task automatic test_burst(input logic [31:0] a);
        logic [2:0] eidx;
        drive(1'b1, 1'b0, 1'b1, a, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL burst_wait_valid got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL burst_wait_ready got %b want 0", req_ready); end
        for (int b = 0; b < 8; b++) begin
            tick();
`ifdef L2_RSP_CRIT_WORD_FIRST_EN
            eidx = 3'(a[2:0] + 3'(b));
`else
            eidx = 3'(b);
`endif
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid beat %0d got %b want 1", b, rsp_valid); end
            n_cmp++; if (rsp_idx !== eidx) begin n_err++; $display("FAIL burst_idx beat %0d got %0d want %0d", b, rsp_idx, eidx); end
            n_cmp++; if (rsp_data !== 32'h100 + 32'(eidx)) begin n_err++; $display("FAIL burst_data beat %0d got %h want %h", b, rsp_data, 32'h100 + 32'(eidx)); end
            n_cmp++; if (rsp_last !== (b == 7)) begin n_err++; $display("FAIL burst_last beat %0d got %b want %b", b, rsp_last, (b == 7)); end
            n_cmp++; if (req_ready !== (b == 7)) begin n_err++; $display("FAIL burst_ready beat %0d got %b want %b", b, req_ready, (b == 7)); end
        end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL burst_end_valid got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL burst_end_ready got %b want 1", req_ready); end
    endtask

    task automatic test_busy_write();
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFE0000);
        tick();
        for (int b = 0; b < 8; b++) begin
            tick();
            n_cmp++; if (req_ready !== (b == 7)) begin n_err++; $display("FAIL busy_ready beat %0d got %b want %b", b, req_ready, (b == 7)); end
            n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL busy_wr_ack beat %0d got %b want 0", b, wr_ack); end
            n_cmp++; if (rsp_data !== 32'h100 + 32'(rsp_idx)) begin n_err++; $display("FAIL busy_data beat %0d got %h want %h", b, rsp_data, 32'h100 + 32'(rsp_idx)); end
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        n_cmp++; if (wr_ack !== 1'b1) begin n_err++; $display("FAIL busy_write_accepted got %b want 1", wr_ack); end
        drive(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); tick();
        n_cmp++; if (rsp_data !== 32'hCAFE0000) begin n_err++; $display("FAIL busy_write_visible got %h want cafe0000", rsp_data); end
        n_cmp++; if (rsp_idx !== 3'd0) begin n_err++; $display("FAIL busy_write_idx got %0d want 0", rsp_idx); end
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick(); tick(); tick(); tick();
        n_cmp++; if (rsp_idx !== 3'd3 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_fourth_beat got idx %0d vld %b want idx 3 vld 1", rsp_idx, rsp_valid); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_abort_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL mid_abort_data got %h want 0", rsp_data); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_resume got %b want 0", rsp_valid); end
        drive(1'b1, 1'b0, 1'b0, 32'h16, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); tick();
        n_cmp++; if (rsp_data !== 32'h106) begin n_err++; $display("FAIL mid_retained got %h want 106", rsp_data); end
        tick();
    endtask

    task automatic test_addr_alias();
        drive(1'b1, 1'b1, 1'b0, 32'h410, 32'hA5A5A5A5);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h010, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); tick();
        n_cmp++; if (rsp_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL alias_data got %h want a5a5a5a5", rsp_data); end
        n_cmp++; if (rsp_last !== 1'b1) begin n_err++; $display("FAIL alias_last got %b want 1", rsp_last); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_single_read();
        preload_line();
        test_burst(32'h10);
        test_burst(32'h15);
        test_busy_write();
        test_reset_mid_read();
        test_addr_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
